// File: rtl/barrel_shifter_pipe_if.sv
// Handshake bundle for barrel_shifter_pipe: input side (valid/ready/operand)
// and output side (valid/ready/result/sticky).
// master drives operands and accepts results; slave is the shifter.
interface barrel_shifter_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter: ROR/ROL/SRL/SLL/SRA, one registered
// mux stage per amount bit, valid/ready on both sides with a global stall.
// Left ops run through the right-shift core on a bit-reversed word.
// Optional feature macro: BARREL_SHIFTER_STICKY_EN builds the sticky
// (OR of shifted-out bits) path; otherwise out_sticky is tied to 0.
module barrel_shifter_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrel_shifter_pipe_if.slave bus
);
  localparam int unsigned AW = $clog2(WIDTH);

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic [AW-1:0] v_vec;
  logic [AW-1:0] en;
  logic          stall;

  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = x[int'(WIDTH) - 1 - i];
    return r;
  endfunction

  function automatic logic is_left(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  // Global stall: only a held result blocks new input.
  assign stall        = v_vec[AW-1] && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Stage load enables: an empty stage always loads, so bubbles collapse.
  always_comb begin
    en       = '0;
    en[AW-1] = !v_vec[AW-1] || bus.out_ready;
    for (int k = int'(AW) - 2; k >= 0; k--) en[k] = !v_vec[k] || en[k+1];
  end

  for (genvar k = 0; k < int'(AW); k++) begin : g_stage
    localparam int unsigned SH = 1 << k;
    localparam int unsigned RW = AW - k;

    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic [RW-1:0]    src_rem;
    logic [2:0]       src_op;
    logic [WIDTH-1:0] shf_d;
    logic [WIDTH-1:0] nxt_d;
    logic             v_q;
    logic [WIDTH-1:0] d_q;
`ifdef BARREL_SHIFTER_STICKY_EN
    logic             src_s;
    logic             shf_s;
    logic             s_q;
`endif

    // Stage source: the input port for stage 0, else the previous stage.
    if (k == 0) begin : g_src_in
      assign src_v   = bus.in_valid && !stall;
      assign src_d   = is_left(bus.in_op) ? reverse(bus.in_data) : bus.in_data;
      assign src_rem = bus.in_amt;
      assign src_op  = bus.in_op;
`ifdef BARREL_SHIFTER_STICKY_EN
      assign src_s   = 1'b0;
`endif
    end else begin : g_src_prev
      assign src_v   = g_stage[k-1].v_q;
      assign src_d   = g_stage[k-1].d_q;
      assign src_rem = g_stage[k-1].g_carry.amt_q;
      assign src_op  = g_stage[k-1].g_carry.op_q;
`ifdef BARREL_SHIFTER_STICKY_EN
      assign src_s   = g_stage[k-1].s_q;
`endif
    end

    // Right shift by 2^k when this stage's amount bit is set.
    always_comb begin
      shf_d = src_d;
`ifdef BARREL_SHIFTER_STICKY_EN
      shf_s = 1'b0;
`endif
      if (src_rem[0]) begin
        case (src_op)
          OP_ROR, OP_ROL: shf_d = {src_d[SH-1:0], src_d[WIDTH-1:SH]};
          OP_SRL, OP_SLL: begin
            shf_d = {{SH{1'b0}}, src_d[WIDTH-1:SH]};
`ifdef BARREL_SHIFTER_STICKY_EN
            shf_s = |src_d[SH-1:0];
`endif
          end
          OP_SRA: begin
            shf_d = {{SH{src_d[WIDTH-1]}}, src_d[WIDTH-1:SH]};
`ifdef BARREL_SHIFTER_STICKY_EN
            shf_s = |src_d[SH-1:0];
`endif
          end
          default: shf_d = src_d;
        endcase
      end
    end

    // Last stage undoes the entry reversal for left ops.
    if (k == int'(AW) - 1) begin : g_exit
      assign nxt_d = is_left(src_op) ? reverse(shf_d) : shf_d;
    end else begin : g_mid
      assign nxt_d = shf_d;
    end

    // Stage valid and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (en[k]) begin
        v_q <= src_v;
        d_q <= nxt_d;
      end
    end

`ifdef BARREL_SHIFTER_STICKY_EN
    // Sticky accumulated across stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      s_q <= 1'b0;
      else if (en[k])  s_q <= src_s | shf_s;
    end
`endif

    assign v_vec[k] = v_q;

    if (k < int'(AW) - 1) begin : g_carry
      logic [RW-2:0] amt_q;
      logic [2:0]    op_q;

      // Remaining amount bits and op travel with the word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q <= '0;
          op_q  <= '0;
        end else if (en[k]) begin
          amt_q <= src_rem[RW-1:1];
          op_q  <= src_op;
        end
      end
    end
  end

  assign bus.out_valid = v_vec[AW-1];
  assign bus.out_data  = g_stage[AW-1].d_q;
`ifdef BARREL_SHIFTER_STICKY_EN
  assign bus.out_sticky = g_stage[AW-1].s_q;
`else
  assign bus.out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (WIDTH=8).
module tb_barrel_shifter_pipe;
  localparam int unsigned W = 8;
  localparam logic [2:0] ROR = 3'b000;
  localparam logic [2:0] ROL = 3'b001;
  localparam logic [2:0] SRL = 3'b010;
  localparam logic [2:0] SLL = 3'b011;
  localparam logic [2:0] SRA = 3'b100;
`ifdef BARREL_SHIFTER_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  barrel_shifter_pipe_if #(.WIDTH(W)) bus ();
  barrel_shifter_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  bit         stalled_prev = 1'b0;
  logic [7:0] held_data;
  logic       held_sticky;
  int         got_cnt = 0;
  logic [7:0] got_data;
  logic       got_sticky;
  logic       last_in_ready;

  // Reference: plain integer arithmetic on the operand; returns {sticky, data}.
  function automatic logic [8:0] model(input logic [7:0] d, input int a, input logic [2:0] op);
    int v, sv, r;
    bit s;
    v  = int'(d);
    sv = (v >= 128) ? v - 256 : v;
    r  = v;
    s  = 1'b0;
    case (op)
      ROR: r = (v >> a) | (v << (8 - a));
      ROL: r = (v << a) | (v >> (8 - a));
      SRL: begin r = v >> a;  s = (v % (1 << a)) != 0; end
      SLL: begin r = v << a;  s = (v >> (8 - a)) != 0; end
      SRA: begin r = sv >>> a; s = (v % (1 << a)) != 0; end
      default: r = v;
    endcase
    return {s & STICKY_ON, r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs already driven at the negedge; check, log transfers, advance.
  task automatic tick(output bit acc);
    logic [8:0] e;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
    if (stalled_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(bus.out_data), 32'(held_data));
      chk("hold_sticky", 32'(bus.out_sticky), 32'(held_sticky));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_out: observed 0x%0h expected no result", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
        chk("out_sticky", 32'(bus.out_sticky), 32'(e[8]));
      end
      got_cnt++;
      got_data   = bus.out_data;
      got_sticky = bus.out_sticky;
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.in_data, int'(bus.in_amt), bus.in_op));
    last_in_ready = bus.in_ready;
    stalled_prev  = bus.out_valid && !bus.out_ready;
    held_data     = bus.out_data;
    held_sticky   = bus.out_sticky;
    @(negedge clk);
  endtask

  // Single op into an empty pipe; out_valid must rise on the 3rd rising edge
  // counting the accept edge as the first.
  task automatic run_one(input logic [7:0] d, input logic [2:0] a, input logic [2:0] op,
                         input logic [7:0] ed, input logic es, input string tag);
    bit acc;
    int edges;
    int c0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_op     = op;
    c0 = got_cnt;
    tick(acc);
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    edges = 1;
    tick(acc);
    while (got_cnt == c0 && edges < 20) begin
      edges++;
      tick(acc);
    end
    if (got_cnt == c0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_timeout: observed no result expected one", tag);
    end else begin
      chk({tag, "_latency"}, 32'(edges), 32'd3);
      chk({tag, "_data"}, 32'(got_data), 32'(ed));
      chk({tag, "_sticky"}, 32'(got_sticky), 32'(es));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit         acc;
    int         n_sent;
    int         c0;
    int         stall_cnt;
    int         tries;
    logic [7:0] sdata[8];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_sticky", 32'(bus.out_sticky), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors.
    run_one(8'hB1, 3'd3, ROR, 8'h36, 1'b0, "ror");
    run_one(8'hB1, 3'd3, ROL, 8'h8D, 1'b0, "rol");
    run_one(8'h81, 3'd1, SLL, 8'h02, STICKY_ON, "sll");
    run_one(8'h93, 3'd2, SRL, 8'h24, STICKY_ON, "srl");
    run_one(8'h90, 3'd2, SRA, 8'hE4, 1'b0, "sra");
    run_one(8'h5A, 3'd4, 3'b101, 8'h5A, 1'b0, "rsvd");
    run_one(8'hC3, 3'd0, SRA, 8'hC3, 1'b0, "amt0");

    // Back-to-back stream of 8 with out_ready low for 5 cycles.
    for (int i = 0; i < 8; i++) sdata[i] = 8'($urandom);
    n_sent    = 0;
    stall_cnt = 0;
    c0        = got_cnt;
    for (int t = 0; t < 60 && (n_sent < 8 || exp_q.size() != 0); t++) begin
      bus.out_ready = !(t >= 4 && t < 9);
      bus.in_valid  = (n_sent < 8);
      if (n_sent < 8) begin
        bus.in_data = sdata[n_sent];
        bus.in_amt  = 3'(n_sent);
        bus.in_op   = 3'(n_sent % 5);
      end
      tick(acc);
      if (acc) n_sent++;
      if (!last_in_ready) stall_cnt++;
    end
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(got_cnt - c0), 32'd8);
    chk("stream_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two ops in flight (one held at the output).
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3C;
    bus.in_amt    = 3'd1;
    bus.in_op     = ROR;
    tick(acc);
    bus.in_data   = 8'hA5;
    bus.in_op     = SRL;
    tick(acc);
    bus.in_valid  = 1'b0;
    tick(acc);
    chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    chk("reset_out_sticky", 32'(bus.out_sticky), 32'd0);
    exp_q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    c0 = got_cnt;
    for (int t = 0; t < 6; t++) tick(acc);
    chk("no_ghost", 32'(got_cnt), 32'(c0));
    run_one(8'h01, 3'd1, ROR, 8'h80, 1'b0, "post_reset");

    // Sweep: every op x amt with random data, then fully random, random backpressure.
    for (int i = 0; i < 214; i++) begin
      bus.in_op   = (i < 64) ? 3'(i % 8) : 3'($urandom_range(0, 7));
      bus.in_amt  = (i < 64) ? 3'(i / 8) : 3'($urandom_range(0, 7));
      bus.in_data = 8'($urandom);
      bus.in_valid = 1'b0;
      for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick(acc);
      end
      bus.in_valid = 1'b1;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 100) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick(acc);
        tries++;
      end
      if (!acc) begin
        vectors++;
        miscompares++;
        $error("FAIL sweep_accept_timeout: observed no accept expected accept");
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick(acc);
    chk("sweep_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
